// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: bird life-cycle states and
// screen geometry constants used by the bird, pipe and draw logic.
package flappy_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFly  = 2'd1,
        StDead = 2'd2
    } bird_state_e;

    localparam int unsigned SCREEN_FLOOR = 116;
    localparam int unsigned SPAWN_Y      = 58;

endpackage

// File: rtl/sat_sub.sv
// Signed subtract with saturation at a lower bound: y = max(a - b, LO).
// The difference is formed one bit wider so it cannot wrap before the clamp.
module sat_sub #(
    parameter int unsigned W  = 6,
    parameter int          LO = -4
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    localparam logic signed [W:0] LoExt = (W+1)'(LO);

    logic signed [W:0] diff;

    // Widened difference, then clamp from below
    always_comb begin
        diff = $signed({a[W-1], a}) - $signed({b[W-1], b});
        if (diff < LoExt) begin
            y = LoExt[W-1:0];
        end else begin
            y = diff[W-1:0];
        end
    end

endmodule

// File: rtl/bird_physics.sv
// Vertical-motion engine for the player bird. Integrates velocity and gravity
// once per step, applies latched flap impulses, clamps at ceiling and floor,
// and tracks the IDLE/FLY/DEAD life cycle. Every output is a register.
module bird_physics
    import flappy_pkg::*;
#(
    parameter int unsigned Y_W       = 8,
    parameter int unsigned V_W       = 6,
    parameter int unsigned Y_START   = SPAWN_Y,
    parameter int unsigned Y_TOP     = 0,
    parameter int unsigned Y_FLOOR   = SCREEN_FLOOR,
    parameter int unsigned FLAP_VEL  = 2,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned VMAX_DOWN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step,
    input  logic                  flap,
    input  logic                  collide,
    output logic [Y_W-1:0]        y_cur,
    output logic [Y_W-1:0]        y_old,
    output logic signed [V_W-1:0] vel,
    output logic                  alive,
    output logic                  step_done,
    output logic                  hit_ceiling,
    output logic                  hit_floor
);

    // Position arithmetic is done two bits wider so overshoot past either
    // boundary is visible as a signed value before clamping.
    localparam int unsigned YN_W = Y_W + 2;

    localparam logic signed [V_W-1:0]  FlapV   = V_W'(FLAP_VEL);
    localparam logic signed [V_W-1:0]  GravV   = V_W'(GRAVITY);
    localparam logic [Y_W-1:0]         YStart  = Y_W'(Y_START);
    localparam logic [Y_W-1:0]         YTop    = Y_W'(Y_TOP);
    localparam logic [Y_W-1:0]         YFloor  = Y_W'(Y_FLOOR);
    localparam logic signed [YN_W-1:0] YTopS   = YN_W'(Y_TOP);
    localparam logic signed [YN_W-1:0] YFloorS = YN_W'(Y_FLOOR);

    bird_state_e           state_q;
    logic [Y_W-1:0]        y_cur_q;
    logic [Y_W-1:0]        y_old_q;
    logic signed [V_W-1:0] vel_q;
    logic                  pend_q;
    logic                  alive_q;
    logic                  step_done_q;
    logic                  hit_ceiling_q;
    logic                  hit_floor_q;

    logic signed [V_W-1:0]  v_eff;
    logic signed [V_W-1:0]  vel_n;
    logic signed [YN_W-1:0] y_n;

    // A flap in the same cycle as the step counts as already latched
    always_comb begin
        v_eff = (pend_q || flap) ? FlapV : vel_q;
        y_n   = $signed({2'b00, y_cur_q})
              - $signed({{(YN_W-V_W){v_eff[V_W-1]}}, v_eff});
    end

    sat_sub #(
        .W  (V_W),
        .LO (-int'(VMAX_DOWN))
    ) u_vel_sub (
        .a (v_eff),
        .b (GravV),
        .y (vel_n)
    );

    // Life-cycle FSM together with flap latch, position and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            y_cur_q       <= YStart;
            y_old_q       <= YStart;
            vel_q         <= '0;
            pend_q        <= 1'b0;
            alive_q       <= 1'b0;
            step_done_q   <= 1'b0;
            hit_ceiling_q <= 1'b0;
            hit_floor_q   <= 1'b0;
        end else begin
            step_done_q   <= 1'b0;
            hit_ceiling_q <= 1'b0;
            hit_floor_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start || flap) begin
                        state_q <= StFly;
                        alive_q <= 1'b1;
                        pend_q  <= flap;
                    end
                end
                StFly: begin
                    if (collide) begin
                        // Collision beats a coincident step: no update
                        state_q <= StDead;
                        alive_q <= 1'b0;
                    end else if (step) begin
                        y_old_q     <= y_cur_q;
                        pend_q      <= 1'b0;
                        step_done_q <= 1'b1;
                        if (y_n < YTopS) begin
                            y_cur_q       <= YTop;
                            vel_q         <= '0;
                            hit_ceiling_q <= 1'b1;
                        end else if (y_n >= YFloorS) begin
                            y_cur_q     <= YFloor;
                            vel_q       <= '0;
                            hit_floor_q <= 1'b1;
                            state_q     <= StDead;
                            alive_q     <= 1'b0;
                        end else begin
                            y_cur_q <= y_n[Y_W-1:0];
                            vel_q   <= vel_n;
                        end
                    end else if (flap) begin
                        pend_q <= 1'b1;
                    end
                end
                StDead: begin
                    if (start) begin
                        state_q <= StIdle;
                        y_cur_q <= YStart;
                        y_old_q <= YStart;
                        vel_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    alive_q <= 1'b0;
                end
            endcase
        end
    end

    assign y_cur       = y_cur_q;
    assign y_old       = y_old_q;
    assign vel         = vel_q;
    assign alive       = alive_q;
    assign step_done   = step_done_q;
    assign hit_ceiling = hit_ceiling_q;
    assign hit_floor   = hit_floor_q;

endmodule
